// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//   Generic pipeline stage register with a valid/ready handshake. It has an
//   optional 2-entry skid buffer, a synchronous flush and bubble insertion.
//   The payload is split into three fields:
//     - CTRL: forced to zero whenever the output is not valid (a NOP).
//   - DATA and SIDE: held as they are and never cleared.
//   A stage holds its entry through back-pressure, so it needs no global clock
//   enable.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_flush                 synchronous flush; squashes every held entry
//   i_valid / o_ready       upstream handshake
//   i_ctrl, i_data, i_side  upstream payload (word k of i_data at [k*W +: W])
//   o_valid / i_ready       downstream handshake
//   o_ctrl, o_data, o_side  head-entry payload (o_ctrl = 0 when !o_valid)
//   o_occ                   entries held: 0 = empty, 1 = full, 2 = skid
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int unsigned XLEN    = 2,   // width code: word = 1 << (XLEN + 4) bits
    parameter int unsigned N_WORDS = 6,
    parameter int unsigned SIDE_W  = 32,
    parameter int unsigned CTRL_W  = 16,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_flush,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [CTRL_W-1:0]                   i_ctrl,
    input  logic [N_WORDS*(1<<(XLEN+4))-1:0]    i_data,
    input  logic [SIDE_W-1:0]                   i_side,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [CTRL_W-1:0]                   o_ctrl,
    output logic [N_WORDS*(1<<(XLEN+4))-1:0]    o_data,
    output logic [SIDE_W-1:0]                   o_side,
    output logic [1:0]                          o_occ
);

    localparam int unsigned DATA_W = N_WORDS * (1 << (XLEN + 4));

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } state_e;

    state_e              r_state;
    logic                r_live;       // low in reset and high from the first edge after release
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [SIDE_W-1:0]   r_main_side;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [SIDE_W-1:0]   r_skid_side;

    logic                w_in;
    logic                w_out;

    assign o_valid = (r_state != StEmpty);
    assign o_ctrl  = o_valid ? r_main_ctrl : '0;
    assign o_data  = r_main_data;
    assign o_side  = r_main_side;
    assign o_occ   = r_state;

    // With no skid, an upstream entry can only be taken when the held one leaves in the same cycle.
    // That gives a combinational path from i_ready to o_ready.
    always_comb begin
        o_ready = 1'b0;
        if (SKID_EN) begin
            o_ready = r_live & (r_state != StSkid);
        end else begin
            o_ready = r_live & (~o_valid | i_ready);
        end
    end

    assign w_in  = i_valid & o_ready;
    assign w_out = o_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StEmpty;
            r_live      <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_main_side <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_side <= '0;
        end else begin
            r_live <= 1'b1;
            if (i_flush) begin
                // DATA/SIDE are deliberately left alone; o_ctrl is gated by o_valid.
                r_state <= StEmpty;
            end else begin
                case (r_state)
                    StEmpty: begin
                        if (w_in) begin
                            r_main_ctrl <= i_ctrl;
                            r_main_data <= i_data;
                            r_main_side <= i_side;
                            r_state     <= StFull;
                        end
                    end
                    StFull: begin
                        if (w_in) begin
                            if (w_out || !SKID_EN) begin
                                r_main_ctrl <= i_ctrl;
                                r_main_data <= i_data;
                                r_main_side <= i_side;
                            end else begin
                                r_skid_ctrl <= i_ctrl;
                                r_skid_data <= i_data;
                                r_skid_side <= i_side;
                                r_state     <= StSkid;
                            end
                        end else if (w_out) begin
                            r_state <= StEmpty;
                        end
                    end
                    StSkid: begin
                        if (w_out) begin
                            r_main_ctrl <= r_skid_ctrl;
                            r_main_data <= r_skid_data;
                            r_main_side <= r_skid_side;
                            r_state     <= StFull;
                        end
                    end
                    default: r_state <= StEmpty;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench: u_dut uses the defaults (64-bit words, skid buffer on).
// u_dut1 is the single-entry variant with 32-bit words.
module tb_pipe_stage_elastic;

    localparam int unsigned DW0 = 6 * 64;
    localparam int unsigned DW1 = 6 * 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            valid;
    logic            ready_out;
    logic [15:0]     ctrl;
    logic [DW0-1:0]  data;
    logic [31:0]     side;
    logic            ovalid;
    logic            dready;
    logic [15:0]     octrl;
    logic [DW0-1:0]  odata;
    logic [31:0]     oside;
    logic [1:0]      occ;

    logic            valid1;
    logic            ready_out1;
    logic [15:0]     ctrl1;
    logic [DW1-1:0]  data1;
    logic [31:0]     side1;
    logic            ovalid1;
    logic            dready1;
    logic [15:0]     octrl1;
    logic [DW1-1:0]  odata1;
    logic [31:0]     oside1;
    logic [1:0]      occ1;
    logic            flush1;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_elastic u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_valid (valid),
        .o_ready (ready_out),
        .i_ctrl  (ctrl),
        .i_data  (data),
        .i_side  (side),
        .o_valid (ovalid),
        .i_ready (dready),
        .o_ctrl  (octrl),
        .o_data  (odata),
        .o_side  (oside),
        .o_occ   (occ)
    );

    pipe_stage_elastic #(
        .XLEN    (1),
        .N_WORDS (6),
        .SIDE_W  (32),
        .CTRL_W  (16),
        .SKID_EN (1'b0)
    ) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush1),
        .i_valid (valid1),
        .o_ready (ready_out1),
        .i_ctrl  (ctrl1),
        .i_data  (data1),
        .i_side  (side1),
        .o_valid (ovalid1),
        .i_ready (dready1),
        .o_ctrl  (octrl1),
        .o_data  (odata1),
        .o_side  (oside1),
        .o_occ   (occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each word is {tag, word index}, so any swapped or stale word is visible.
    function automatic logic [DW0-1:0] mk_data(input int tag);
        logic [DW0-1:0] d;
        for (int w = 0; w < 6; w++) d[w*64 +: 64] = {32'(tag), 32'(w)};
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input int tag);
        valid = v;
        ctrl  = 16'(tag);
        data  = mk_data(tag);
        side  = 32'(tag) ^ 32'hA5A5_0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ovalid !== 1'b0 || octrl !== 16'h0 || occ !== 2'd0 || ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b ctrl=%h occ=%0d ready=%b required 0/0000/0/0",
                     ovalid, octrl, occ, ready_out);
        end
        n_cmp++;
        if (odata !== '0 || oside !== 32'h0) begin
            n_err++;
            $display("FAIL reset_payload: data=%h side=%h required 0", odata, oside);
        end
        step();
        step();
        #2 rst_n = 1'b1;                // release between edges
        #1;
        n_cmp++;
        if (ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: ready=%b required 0", ready_out);
        end
        step();
        n_cmp++;
        if (ready_out !== 1'b1 || ready_out1 !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_release: ready=%b ready1=%b required 1/1",
                     ready_out, ready_out1);
        end
    endtask

    task automatic test_streaming();
        dready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            offer(1'b1, k);
            n_cmp++;
            if (ready_out !== 1'b1) begin
                n_err++;
                $display("FAIL stream_ready[%0d]: ready=%b required 1", k, ready_out);
            end
            step();
            n_cmp++;
            if (ovalid !== 1'b1 || octrl !== 16'(k) || occ !== 2'd1 || odata !== mk_data(k) ||
                oside !== (32'(k) ^ 32'hA5A5_0000)) begin
                n_err++;
                $display("FAIL stream_out[%0d]: valid=%b ctrl=%h occ=%0d side=%h required 1/%h/1/%h",
                         k, ovalid, octrl, occ, oside, 16'(k), 32'(k) ^ 32'hA5A5_0000);
            end
        end
        offer(1'b0, 0);
        step();
        n_cmp++;
        if (ovalid !== 1'b0 || occ !== 2'd0 || octrl !== 16'h0) begin
            n_err++;
            $display("FAIL stream_drain: valid=%b occ=%0d ctrl=%h required 0/0/0000",
                     ovalid, occ, octrl);
        end
    endtask

    task automatic test_back_pressure();
        dready = 1'b0;
        offer(1'b1, 16'hA);
        step();
        offer(1'b1, 16'hB);
        n_cmp++;
        if (ready_out !== 1'b1 || occ !== 2'd1) begin
            n_err++;
            $display("FAIL bp_first: ready=%b occ=%0d required 1/1", ready_out, occ);
        end
        step();
        offer(1'b1, 16'hC);
        n_cmp++;
        if (ready_out !== 1'b0 || occ !== 2'd2 || octrl !== 16'hA) begin
            n_err++;
            $display("FAIL bp_full: ready=%b occ=%0d ctrl=%h required 0/2/000a",
                     ready_out, occ, octrl);
        end
        step();
        n_cmp++;
        if (occ !== 2'd2 || octrl !== 16'hA || odata !== mk_data(16'hA)) begin
            n_err++;
            $display("FAIL bp_hold: occ=%0d ctrl=%h required 2/000a", occ, octrl);
        end
        dready = 1'b1;
        step();
        n_cmp++;
        if (octrl !== 16'hB || occ !== 2'd1 || odata !== mk_data(16'hB)) begin
            n_err++;
            $display("FAIL bp_out_b: ctrl=%h occ=%0d required 000b/1", octrl, occ);
        end
        step();
        n_cmp++;
        if (octrl !== 16'hC || occ !== 2'd1 || odata !== mk_data(16'hC)) begin
            n_err++;
            $display("FAIL bp_out_c: ctrl=%h occ=%0d required 000c/1", octrl, occ);
        end
        offer(1'b0, 0);
        step();
        n_cmp++;
        if (ovalid !== 1'b0 || occ !== 2'd0) begin
            n_err++;
            $display("FAIL bp_drain: valid=%b occ=%0d required 0/0", ovalid, occ);
        end
    endtask

    task automatic test_flush();
        dready = 1'b0;
        offer(1'b1, 16'h11);
        step();
        offer(1'b1, 16'h22);
        step();
        offer(1'b1, 16'h33);
        flush = 1'b1;
        n_cmp++;
        if (occ !== 2'd2) begin
            n_err++;
            $display("FAIL flush_pre: occ=%0d required 2", occ);
        end
        step();
        flush = 1'b0;
        offer(1'b0, 0);
        n_cmp++;
        if (ovalid !== 1'b0 || octrl !== 16'h0 || occ !== 2'd0) begin
            n_err++;
            $display("FAIL flush_skid: valid=%b ctrl=%h occ=%0d required 0/0000/0",
                     ovalid, octrl, occ);
        end
        // Flush from one entry, while o_ready=1; the offered entry must be dropped.
        offer(1'b1, 16'h44);
        step();
        offer(1'b1, 16'h55);
        flush = 1'b1;
        step();
        flush = 1'b0;
        offer(1'b0, 0);
        n_cmp++;
        if (ovalid !== 1'b0 || octrl !== 16'h0 || occ !== 2'd0) begin
            n_err++;
            $display("FAIL flush_full: valid=%b ctrl=%h occ=%0d required 0/0000/0",
                     ovalid, octrl, occ);
        end
        step();
        n_cmp++;
        if (ovalid !== 1'b0 || occ !== 2'd0) begin
            n_err++;
            $display("FAIL flush_no_leak: valid=%b occ=%0d required 0/0", ovalid, occ);
        end
    endtask

    task automatic test_bubble();
        dready = 1'b1;
        valid  = 1'b0;
        ctrl   = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (ovalid !== 1'b0 || octrl !== 16'h0) begin
                n_err++;
                $display("FAIL bubble[%0d]: valid=%b ctrl=%h required 0/0000", i, ovalid, octrl);
            end
        end
    endtask

    task automatic test_mid_reset();
        dready = 1'b0;
        offer(1'b1, 16'h66);
        step();
        offer(1'b1, 16'h77);
        step();
        offer(1'b0, 0);
        rst_n = 1'b0;                   // mid-cycle, asynchronous
        #1;
        n_cmp++;
        if (ovalid !== 1'b0 || octrl !== 16'h0 || occ !== 2'd0 || ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: valid=%b ctrl=%h occ=%0d ready=%b required 0/0000/0/0",
                     ovalid, octrl, occ, ready_out);
        end
        step();
        #2 rst_n = 1'b1;
        step();
        n_cmp++;
        if (ready_out !== 1'b1 || ovalid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_release: ready=%b valid=%b required 1/0", ready_out, ovalid);
        end
    endtask

    task automatic test_no_skid();
        int sent = 0;
        int rcvd = 0;
        logic fire_in;
        logic fire_out;
        for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
            dready1 = (cyc % 2 == 0);
            valid1  = (sent < 6);
            ctrl1   = 16'(sent + 1);
            data1   = '0;
            data1[31:0]  = 32'hDEADBEEF;
            data1[63:32] = 32'(sent + 1);
            side1   = 32'(sent + 1);
            #1;
            n_cmp++;
            if (ready_out1 !== (~ovalid1 | dready1)) begin
                n_err++;
                $display("FAIL noskid_ready[%0d]: ready=%b required %b", cyc, ready_out1,
                         ~ovalid1 | dready1);
            end
            fire_in  = valid1 & ready_out1;
            fire_out = ovalid1 & dready1;
            if (fire_out) begin
                n_cmp++;
                if (octrl1 !== 16'(rcvd + 1) || odata1[31:0] !== 32'hDEADBEEF ||
                    odata1[63:32] !== 32'(rcvd + 1)) begin
                    n_err++;
                    $display("FAIL noskid_out[%0d]: ctrl=%h word0=%h word1=%h required %h/deadbeef/%h",
                             rcvd, octrl1, odata1[31:0], odata1[63:32], 16'(rcvd + 1),
                             32'(rcvd + 1));
                end
                rcvd++;
            end
            if (fire_in) sent++;
            step();
        end
        valid1 = 1'b0;
        n_cmp++;
        if (sent !== 6 || rcvd !== 6) begin
            n_err++;
            $display("FAIL noskid_count: sent=%0d received=%0d required 6/6", sent, rcvd);
        end
        step();
        n_cmp++;
        if (ovalid1 !== 1'b0 || occ1 !== 2'd0) begin
            n_err++;
            $display("FAIL noskid_empty: valid=%b occ=%0d required 0/0", ovalid1, occ1);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        flush1  = 1'b0;
        dready  = 1'b0;
        dready1 = 1'b0;
        valid1  = 1'b0;
        ctrl1   = '0;
        data1   = '0;
        side1   = '0;
        offer(1'b0, 0);
        #2;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_bubble();
        test_mid_reset();
        test_no_skid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
